// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller and the fetch stage.
package imem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } ld_state_e;

    localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader stream, fetch-stage and instruction-memory control signals of imem_load_ctrl.
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              fetch_req;
    logic              fetch_stall;
    logic              fetch_flush;
    logic              imem_read_en;
    logic              imem_write_en;
    logic              imem_flush;
    logic [ADDR_W-1:0] imem_write_addr;
    logic [31:0]       imem_write_data;
    logic              cpu_hold;
    logic              load_busy;
    logic              load_done;
    logic [ADDR_W:0]   words_written;

    modport master (
        output load_start, load_base, load_len, ld_valid, ld_data,
               fetch_req, fetch_stall, fetch_flush,
        input  ld_ready, imem_read_en, imem_write_en, imem_flush,
               imem_write_addr, imem_write_data, cpu_hold, load_busy,
               load_done, words_written
    );

    modport slave (
        input  load_start, load_base, load_len, ld_valid, ld_data,
               fetch_req, fetch_stall, fetch_flush,
        output ld_ready, imem_read_en, imem_write_en, imem_flush,
               imem_write_addr, imem_write_data, cpu_hold, load_busy,
               load_done, words_written
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Streams a program image into instruction memory, flushes, then hands the memory to fetch.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    imem_load_ctrl_if.slave  bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [ADDR_W:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [FC_W-1:0] FLUSH_ONE  = {{(FC_W-1){1'b0}}, 1'b1};
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              done_q, done_d;

    logic              start_ok;
    logic              ld_ready;
    logic              read_en;
    logic              write_en;
    logic              flush;
    logic              cpu_hold;
    logic              load_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            flush_cnt_q <= '0;
            base_q      <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            base_q      <= base_d;
            len_q       <= len_d;
            done_q      <= done_d;
        end
    end

    // A start seen while rst is still high must not leak a load_done pulse.
    assign start_ok = bus.load_start & ~rst;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        base_d      = base_q;
        len_d       = len_q;
        done_d      = 1'b0;
        ld_ready    = 1'b0;
        read_en     = 1'b0;
        write_en    = 1'b0;
        flush       = 1'b0;
        cpu_hold    = 1'b1;
        load_done   = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    base_d      = bus.load_base;
                    len_d       = bus.load_len;
                    count_d     = '0;
                    flush_cnt_d = '0;
                    if (bus.load_len != '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d   = ST_FLUSH;
                        load_done = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    write_en = 1'b1;
                    count_d  = count_q + CNT_ONE;
                    if (count_d == len_q) begin
                        state_d     = ST_FLUSH;
                        done_d      = 1'b1;
                        flush_cnt_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_ONE;
                end
            end
            ST_RUN: begin
                cpu_hold = 1'b0;
                flush    = bus.fetch_flush;
                read_en  = bus.fetch_req & ~bus.fetch_stall;
                if (start_ok) begin
                    // The reload cycle gives the memory port to the loader.
                    read_en     = 1'b0;
                    base_d      = bus.load_base;
                    len_d       = bus.load_len;
                    count_d     = '0;
                    flush_cnt_d = '0;
                    if (bus.load_len != '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d   = ST_FLUSH;
                        load_done = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ld_ready        = ld_ready;
    assign bus.imem_read_en    = read_en;
    assign bus.imem_write_en   = write_en;
    assign bus.imem_flush      = flush;
    assign bus.imem_write_addr = base_q + count_q[ADDR_W-1:0];
    assign bus.imem_write_data = write_en ? bus.ld_data : 32'd0;
    assign bus.cpu_hold        = cpu_hold;
    assign bus.load_busy       = (state_q == ST_LOAD);
    assign bus.load_done       = load_done;
    assign bus.words_written   = count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl against a transaction-level load/flush/run model.
module tb_imem_load_ctrl;
    import imem_load_ctrl_pkg::*;

    localparam int AW = 8;
    localparam int FC = FLUSH_CYCLES_DEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    imem_load_ctrl_if #(.ADDR_W(AW)) bus ();

    imem_load_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hold"},  bus.cpu_hold, 1);
        check_val({tag, "_rdy"},   bus.ld_ready, 0);
        check_val({tag, "_rd"},    bus.imem_read_en, 0);
        check_val({tag, "_wr"},    bus.imem_write_en, 0);
        check_val({tag, "_flush"}, bus.imem_flush, 0);
        check_val({tag, "_busy"},  bus.load_busy, 0);
        check_val({tag, "_done"},  bus.load_done, 0);
        check_val({tag, "_words"}, bus.words_written, 0);
        check_val({tag, "_wdata"}, bus.imem_write_data, 0);
    endtask

    // Idle/hold cycles: nothing may reach the memory while the CPU is held.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.load_start = 1'b0;
            bus.fetch_req  = 1'b1;
            bus.ld_valid   = 1'($urandom);
            #1;
            check_val("idle_hold", bus.cpu_hold, 1);
            check_val("idle_rd",   bus.imem_read_en, 0);
            check_val("idle_wr",   bus.imem_write_en, 0);
            check_val("idle_rdy",  bus.ld_ready, 0);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic run_cycle(input bit req, input bit stall, input bit fl);
        @(negedge clk);
        bus.load_start  = 1'b0;
        bus.ld_valid    = 1'($urandom);
        bus.fetch_req   = req;
        bus.fetch_stall = stall;
        bus.fetch_flush = fl;
        #1;
        check_val("run_rd",    bus.imem_read_en, 32'(req & ~stall));
        check_val("run_flush", bus.imem_flush, 32'(fl));
        check_val("run_wr",    bus.imem_write_en, 0);
        check_val("run_hold",  bus.cpu_hold, 0);
        check_val("run_rdy",   bus.ld_ready, 0);
        check_val("run_done",  bus.load_done, 0);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(1'($urandom), 1'($urandom), 1'($urandom));
        $display("run burst: %0d fetch cycles", n);
    endtask

    // One program load. Word k goes to (base+k) mod 256 with data dseed+k.
    // Valid for the first 32 cycles comes from vmask, then random or always-on.
    // abort_after >= 0 asserts rst once that many words have been written.
    task automatic do_load(input logic [AW-1:0] base, input logic [AW:0] len,
                           input logic [31:0] dseed, input logic [31:0] vmask,
                           input bit vrand, input int abort_after);
        int k;
        int cyc;
        bit v;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        bus.load_start  = 1'b1;
        bus.load_base   = base;
        bus.load_len    = len;
        bus.ld_valid    = 1'b0;
        bus.fetch_req   = 1'b1;
        bus.fetch_stall = 1'b0;
        bus.fetch_flush = 1'b0;
        #1;
        check_val("start_rd",   bus.imem_read_en, 0);
        check_val("start_wr",   bus.imem_write_en, 0);
        check_val("start_done", bus.load_done, 32'(len == 0));
        k = 0;
        cyc = 0;
        while (k < int'(len)) begin
            @(negedge clk);
            if (abort_after >= 0 && k == abort_after) begin
                rst            = 1'b1;
                bus.ld_valid   = 1'b1;
                bus.load_start = 1'b0;
                #1;
                check_reset_outputs("abort");
                $display("load base=0x%02h len=%0d aborted after %0d words", base, len, k);
                return;
            end
            v = (cyc < 32) ? vmask[cyc] : (vrand ? 1'($urandom) : 1'b1);
            bus.ld_valid   = v;
            bus.ld_data    = dseed + 32'(k);
            bus.load_start = ($urandom_range(0, 3) == 0);
            bus.load_len   = (AW+1)'($urandom);
            bus.load_base  = AW'($urandom);
            bus.fetch_req  = 1'($urandom);
            #1;
            check_val("load_rdy",   bus.ld_ready, 1);
            check_val("load_busy",  bus.load_busy, 1);
            check_val("load_rd",    bus.imem_read_en, 0);
            check_val("load_hold",  bus.cpu_hold, 1);
            check_val("load_done",  bus.load_done, 0);
            check_val("load_words", bus.words_written, 32'(k));
            check_val("load_wr",    bus.imem_write_en, 32'(v));
            if (v) begin
                exp_addr = AW'((int'(base) + k) % 256);
                check_val("load_addr", bus.imem_write_addr, 32'(exp_addr));
                check_val("load_data", bus.imem_write_data, dseed + 32'(k));
                k++;
            end
            cyc++;
            if (cyc > 4000) begin
                check_val("load_timeout", 0, 1);
                return;
            end
        end
        for (int i = 0; i < FC; i++) begin
            @(negedge clk);
            bus.ld_valid   = 1'($urandom);
            bus.load_start = 1'($urandom);
            bus.load_len   = (AW+1)'($urandom);
            bus.fetch_req  = 1'b1;
            #1;
            check_val("flush_flush", bus.imem_flush, 1);
            check_val("flush_hold",  bus.cpu_hold, 1);
            check_val("flush_rdy",   bus.ld_ready, 0);
            check_val("flush_wr",    bus.imem_write_en, 0);
            check_val("flush_rd",    bus.imem_read_en, 0);
            check_val("flush_busy",  bus.load_busy, 0);
            check_val("flush_done",  bus.load_done, 32'(i == 0 && len != 0));
            check_val("flush_words", bus.words_written, 32'(len));
        end
        @(negedge clk);
        bus.load_start  = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.fetch_req   = 1'b0;
        bus.fetch_flush = 1'b0;
        #1;
        check_val("enter_run_hold",  bus.cpu_hold, 0);
        check_val("enter_run_flush", bus.imem_flush, 0);
        check_val("enter_run_words", bus.words_written, 32'(len));
        $display("load base=0x%02h len=%0d done in %0d stream cycles", base, len, cyc);
    endtask

    initial begin
        bus.load_start  = 1'b0;
        bus.load_base   = '0;
        bus.load_len    = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;
        bus.fetch_req   = 1'b0;
        bus.fetch_stall = 1'b0;
        bus.fetch_flush = 1'b0;

        // Reset with every input provoking activity.
        #2;
        rst            = 1'b1;
        bus.load_start = 1'b1;
        bus.load_len   = 9'd3;
        bus.ld_valid   = 1'b1;
        bus.fetch_req  = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst            = 1'b0;
        bus.load_start = 1'b0;
        bus.ld_valid   = 1'b0;
        idle_cycles(3);

        // Basic load, wrapping load, and a stalled stream with valid 1,0,0,1.
        do_load(8'h10, 9'd3, 32'hA, 32'hFFFF_FFFF, 1'b0, -1);
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0);
        do_load(8'hFE, 9'd4, $urandom, 32'hFFFF_FFFF, 1'b0, -1);
        do_load(8'h30, 9'd2, $urandom, 32'hFFFF_FFF9, 1'b0, -1);
        run_random(4);

        // Reset in the middle of a five-word load.
        do_load(8'h40, 9'd5, $urandom, 32'hFFFF_FFFF, 1'b0, 2);
        @(negedge clk);
        #1;
        check_reset_outputs("abort_held");
        rst = 1'b0;
        idle_cycles(3);

        // Zero-length load from IDLE, then from RUN.
        do_load(8'h22, 9'd0, $urandom, 32'hFFFF_FFFF, 1'b0, -1);
        run_random(3);
        do_load(8'h23, 9'd0, $urandom, 32'hFFFF_FFFF, 1'b0, -1);
        run_random(3);

        // Full-memory load and random loads with random valid gaps.
        do_load(AW'($urandom), 9'd256, $urandom, $urandom, 1'b1, -1);
        for (int t = 0; t < 10; t++) begin
            do_load(AW'($urandom), (t % 4 == 3) ? 9'd0 : 9'($urandom_range(1, 40)),
                    $urandom, $urandom, 1'b1, -1);
            run_random(int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (256 words).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles imem_flush is held after a load.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load_start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 SHALL have port load_base, input, ADDR_W bits: first word address of the load, sampled with load_start.
REQ-007 SHALL have port load_len, input, ADDR_W+1 bits: number of words to load (0..256), sampled with load_start.
REQ-008 SHALL have ports ld_valid (input, 1), ld_data (input, 32) and ld_ready (output, 1): the loader word stream.
REQ-009 SHALL have ports fetch_req (input, 1), fetch_stall (input, 1) and fetch_flush (input, 1): the fetch-stage read request, pipeline stall and branch flush.
REQ-010 SHALL have ports imem_read_en, imem_write_en, imem_flush (outputs, 1 each), imem_write_addr (output, ADDR_W) and imem_write_data (output, 32): the instruction-memory control port.
REQ-011 SHALL have ports cpu_hold (output, 1), load_busy (output, 1), load_done (output, 1, one-cycle pulse) and words_written (output, ADDR_W+1).

Function
REQ-012 SHALL implement an FSM with states IDLE, LOAD, FLUSH and RUN.
REQ-013 IDLE: cpu_hold=1; load_start -> LOAD when load_len!=0, else -> FLUSH with load_done pulsed in that same transition cycle.
REQ-014 LOAD: ld_ready=1; each cycle with ld_valid&ld_ready SHALL drive imem_write_en=1, imem_write_addr=(load_base+count) mod 2^ADDR_W and imem_write_data=ld_data, all combinationally in that cycle, and then increment count.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_W; base 0xFE with length 4 writes 0xFE, 0xFF, 0x00, 0x01.
REQ-016 The handshake accepting word load_len SHALL pulse load_done on the next cycle, deassert ld_ready from that next cycle on, and move the FSM to FLUSH.
REQ-017 FLUSH: imem_flush=1 and cpu_hold=1 for exactly FLUSH_CYCLES cycles, then -> RUN.
REQ-018 RUN: cpu_hold=0, imem_read_en = fetch_req & ~fetch_stall, imem_flush = fetch_flush, imem_write_en=0.
REQ-019 load_start in RUN SHALL reload: imem_read_en=0 in that same cycle, then -> LOAD (or -> FLUSH when load_len=0).
REQ-020 load_start in LOAD or FLUSH SHALL be ignored.
REQ-021 imem_read_en and imem_write_en SHALL never be 1 in the same cycle.
REQ-022 imem_read_en SHALL be 0 in IDLE, LOAD and FLUSH, regardless of fetch_req.
REQ-023 load_busy SHALL be 1 exactly in LOAD.
REQ-024 words_written SHALL equal count, clear on accepted load_start, and hold its final value after the load.
REQ-025 ld_valid low in LOAD SHALL stall the load indefinitely with no write, no address advance and no timeout.
REQ-026 load_len=256 SHALL write all 256 words, the final write landing at load_base-1 mod 256.

Reset
REQ-027 rst SHALL force, asynchronously, state=IDLE, count=0, flush counter=0, latched base/len=0.
REQ-028 While in reset, cpu_hold=1 and every other output SHALL be 0.
REQ-029 A reset during LOAD SHALL abort the load with no further writes; the words already written stay in memory.

Structure
REQ-030 The FSM state encoding and the FLUSH_CYCLES default SHALL live in a shared package used with the fetch stage.
REQ-031 The block SHALL be a single module with no sub-module; the address/count logic is inline.

Verification
REQ-032 Reset then load_start with base=0x10, len=3, and data 0xA,0xB,0xC on consecutive cycles -> writes to 0x10,0x11,0x12, then load_done, 2 flush cycles, cpu_hold=0.
REQ-033 base=0xFE, len=4 -> write addresses 0xFE,0xFF,0x00,0x01; words_written=4.
REQ-034 ld_valid toggled 1,0,0,1 during a load -> only 2 writes, address advanced by 2, ld_ready held 1.
REQ-035 In RUN, fetch_req=1 and fetch_stall=1 -> imem_read_en=0; fetch_flush=1 -> imem_flush=1.
REQ-036 rst asserted mid-load after 2 of 5 words -> IDLE immediately, no further writes, cpu_hold=1.
REQ-037 load_start with len=0 in RUN -> no writes, load_done pulse, FLUSH_CYCLES flush cycles, back to RUN.
